byte_word_loader: RTL and testbench

//  Pin-side loader. Takes bytes from the 8-bit uio_in pins, qualified by an

---
 rtl/byte_word_loader.sv | 130 +++++++++++++
 tb/tb_byte_word_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_word_loader.sv
// Pin-side loader: packs strobed bytes from uio pins into 32-bit words and writes them to RAM
// at auto-incrementing addresses. Byte 0 lands in bits [7:0].
module byte_word_loader #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        byte_in,
    input  logic              byte_strobe,
    input  logic              load_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              load_active,
    output logic              busy,
    output logic              overflow,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] strobe_sync_q, load_sync_q;
    logic                   strobe_prev_q, strobe_edge_q;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [31:0]            asm_q, asm_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   we_pend_q, we_pend_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   ovf_q, ovf_d;
    logic [ADDR_W:0]        words_q, words_d;
    logic                   strobe_s, load_s;

    assign strobe_s = strobe_sync_q[SYNC_STAGES-1];
    assign load_s   = load_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_sync_q <= '0;
            load_sync_q   <= '0;
            strobe_prev_q <= 1'b0;
            strobe_edge_q <= 1'b0;
        end else begin
            strobe_sync_q <= {strobe_sync_q[SYNC_STAGES-2:0], byte_strobe};
            load_sync_q   <= {load_sync_q[SYNC_STAGES-2:0], load_en};
            strobe_prev_q <= strobe_s;
            // Registered edge: one capture per rising edge however long the strobe is held
            strobe_edge_q <= strobe_s & ~strobe_prev_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            byte_idx_q <= '0;
            asm_q      <= '0;
            wdata_q    <= '0;
            we_pend_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            ovf_q      <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            wdata_q    <= wdata_d;
            we_pend_q  <= we_pend_d;
            mem_we_q   <= mem_we_d;
            addr_q     <= addr_d;
            ovf_q      <= ovf_d;
            words_q    <= words_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        wdata_d    = wdata_q;
        we_pend_d  = 1'b0;
        mem_we_d   = 1'b0;
        addr_d     = addr_q;
        ovf_d      = ovf_q;
        words_d    = words_q;
        unique case (state_q)
            StIdle: begin
                byte_idx_d = '0;
                addr_d     = '0;
                ovf_d      = 1'b0;
                words_d    = '0;
                if (load_s) state_d = StCollect;
            end
            StCollect: begin
                if (!load_s) begin
                    // Abort: partial word and any pending write are dropped
                    state_d    = StIdle;
                    byte_idx_d = '0;
                end else begin
                    mem_we_d = we_pend_q;
                    if (mem_we_q) begin
                        addr_d = addr_q + 1'b1;
                        if (addr_q == {ADDR_W{1'b1}}) ovf_d = 1'b1;
                        if (words_q != {(ADDR_W+1){1'b1}}) words_d = words_q + 1'b1;
                    end
                    if (strobe_edge_q) begin
                        asm_d[8*byte_idx_q +: 8] = byte_in;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            wdata_d   = {byte_in, asm_q[23:0]};
                            we_pend_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_we        = mem_we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign load_active   = (state_q == StCollect);
    assign busy          = (byte_idx_q != 2'd0) | we_pend_q | mem_we_q;
    assign overflow      = ovf_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_byte_word_loader.sv
// Scoreboard bench for byte_word_loader: stimulus pushes expected {addr,data} writes, a monitor
// pops and compares on every mem_we pulse.
module tb_byte_word_loader;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_strobe = 1'b0;
    logic              load_en = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              load_active;
    logic              busy;
    logic              overflow;
    logic [ADDR_W:0]   words_written;

    int total = 0;
    int bad   = 0;
    logic [ADDR_W+31:0] exp_q[$];

    always #5 clk = ~clk;

    byte_word_loader #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_strobe(byte_strobe),
        .load_en(load_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .load_active(load_active), .busy(busy), .overflow(overflow),
        .words_written(words_written)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                         mem_addr, mem_wdata);
            end else begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e[ADDR_W+31:32]));
                chk("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic push_exp(input int addr, input logic [31:0] data);
        exp_q.push_back({addr[ADDR_W-1:0], data});
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        byte_in = b;
        byte_strobe = 1'b1;
        repeat (hold) @(negedge clk);
        byte_strobe = 1'b0;
        repeat (2 * SYNC_STAGES) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int hold);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], hold);
    endtask

    task automatic restart_session();
        @(negedge clk);
        load_en = 1'b0;
        repeat (6) @(negedge clk);
        load_en = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, {28'd0, mem_we, load_active, busy, overflow}, 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_words"}, 32'(words_written), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // T1: reset with pins toggling, then strobes with load_en low
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            byte_strobe = ~byte_strobe;
            load_en = ~load_en;
            byte_in = 8'(i * 37);
        end
        chk_all_zero("reset");
        @(negedge clk);
        byte_strobe = 1'b0;
        load_en = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'hE0 + 8'(i), 4);
        repeat (6) @(negedge clk);
        chk("idle_words", 32'(words_written), 32'd0);
        chk("idle_active", 32'(load_active), 32'd0);

        // T2: single word plus latency from the sampling edge of the 4th strobe
        load_en = 1'b1;
        repeat (8) @(negedge clk);
        chk("t2_active", 32'(load_active), 32'd1);
        push_exp(0, 32'h44332211);
        send_byte(8'h11, 4);
        send_byte(8'h22, 4);
        send_byte(8'h33, 4);
        chk("t2_busy_partial", 32'(busy), 32'd1);
        @(negedge clk);
        byte_in = 8'h44;
        byte_strobe = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (n == 4) byte_strobe = 1'b0;
            if (mem_we) break;
        end
        // n counts posedges; the first one samples the strobe, the pulse follows SYNC_STAGES+2 later
        chk("t2_latency", 32'(n), 32'(SYNC_STAGES + 3));
        byte_strobe = 1'b0;
        repeat (4) @(negedge clk);
        chk("t2_words", 32'(words_written), 32'd1);
        chk("t2_addr", 32'(mem_addr), 32'd1);
        chk("t2_busy_done", 32'(busy), 32'd0);

        // T3: 33 words wrap to address 0
        restart_session();
        chk("t3_cleared_addr", 32'(mem_addr), 32'd0);
        for (int i = 0; i < 33; i++) begin
            push_exp(i % 32, 32'(i));
            send_word(32'(i), 4);
            if (i == 30) begin
                repeat (4) @(negedge clk);
                chk("t3_no_ovf_31", 32'(overflow), 32'd0);
            end
        end
        repeat (4) @(negedge clk);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_words", 32'(words_written), 32'd33);
        chk("t3_addr", 32'(mem_addr), 32'd1);

        // T4: abort mid-word
        restart_session();
        send_byte(8'h01, 4);
        send_byte(8'h02, 4);
        load_en = 1'b0;
        repeat (4) @(negedge clk);
        load_en = 1'b1;
        repeat (6) @(negedge clk);
        chk("t4_ovf_cleared", 32'(overflow), 32'd0);
        push_exp(0, 32'hDDCCBBAA);
        send_word(32'hDDCCBBAA, 4);
        repeat (4) @(negedge clk);
        chk("t4_words", 32'(words_written), 32'd1);
        chk("t4_overflow", 32'(overflow), 32'd0);

        // T5: long strobe hold
        restart_session();
        push_exp(0, 32'hCAFEF00D);
        send_word(32'hCAFEF00D, 20);
        repeat (4) @(negedge clk);
        chk("t5_words", 32'(words_written), 32'd1);

        // T6: async reset mid-word
        restart_session();
        send_byte(8'h91, 4);
        send_byte(8'h92, 4);
        send_byte(8'h93, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        push_exp(0, 32'h5A6B7C8D);
        send_word(32'h5A6B7C8D, 4);
        repeat (4) @(negedge clk);
        chk("t6_words", 32'(words_written), 32'd1);
        chk("t6_addr", 32'(mem_addr), 32'd1);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
